axis_adc_decimator: RTL and testbench
=====================================

Name: axis_adc_decimator

Overview:
- Consumes the always-valid 32-bit two-channel ADC sample stream from the ADC readout stage. Each 16-bit half carries one channel, right-aligned.
- Averages blocks of 2^L consecutive samples per channel, with L selectable at run time.
- Emits one averaged two-channel word per block on an AXI-Stream master with backpressure.
- Sits between the ADC readout stage and the DMA/FIFO writer. It reduces sample rate and adds resolution-preserving averaging.

Parameters:
- INT_ADC_DATA_WIDTH, 10, valid bits per channel in each 16-bit half; must be <= INT_AXIS_DATA_WIDTH/2.
- INT_AXIS_DATA_WIDTH, 32, input and output stream width; exactly two channels per word.
- INT_MAX_LOG2_DECIM, 8, maximum L; the accumulator is INT_ADC_DATA_WIDTH+INT_MAX_LOG2_DECIM bits per channel.
- BIT_SIGNED_DATA, 0, 1: samples are two's complement (sign-extend, arithmetic shift); 0: samples are unsigned (zero-extend, logical shift).

Ports:
- in_clk  input  1  single clock for all logic.
- in_rst  input  1  synchronous, active-high reset.
- in_enable  input  1  1: accept beats; 0: discard input and clear the partial block.
- in_log2_decim  input  4  requested L; values above INT_MAX_LOG2_DECIM are clamped to INT_MAX_LOG2_DECIM.
- s_axis_valid  input  1  input beat valid (upstream holds this at 1).
- s_axis_data  input  INT_AXIS_DATA_WIDTH  ch A in [W-1:0], ch B in [16+W-1:16], where W = INT_ADC_DATA_WIDTH.
- s_axis_ready  output  1  constant 1; input is never stalled.
- m_axis_valid  output  1  averaged word available.
- m_axis_ready  input  1  downstream accepts.
- m_axis_data  output  INT_AXIS_DATA_WIDTH  averaged ch B in [31:16], ch A in [15:0]; each half zero- or sign-extended to 16 bits per BIT_SIGNED_DATA.
- out_overflow  output  1  sticky: a completed result was dropped due to backpressure.

Behaviour:
- Reset values: m_axis_valid=0, m_axis_data=0, out_overflow=0, accumulators=0, beat counter=0, latched L=0.
- Accepted beat: s_axis_valid & in_enable.
- Elaboration error if INT_ADC_DATA_WIDTH > INT_AXIS_DATA_WIDTH/2 or INT_AXIS_DATA_WIDTH is odd.
- Block start (counter==0 with an accepted beat): latch L_blk = min(in_log2_decim, INT_MAX_LOG2_DECIM).
  - Changes to in_log2_decim mid-block take effect at the next block start only.
- Per accepted beat, each channel: acc <= (counter==0 ? sample : acc + sample), with samples extended to the accumulator width.
- Counter increments per accepted beat and wraps to 0 after beat 2^L_blk - 1 (the final beat).
- Final beat: result = (acc + sample) >> L_blk, arithmetic if signed, logical if unsigned; i.e. floor, no rounding.
  - The result is loaded into the output register in the same clock edge.
  - m_axis_valid is high the cycle after the final beat, giving latency 1 cycle from the final input beat.
- L_blk=0 is pass-through: each beat appears on the output 1 cycle later with the same value, halves re-extended.
- Output register is a single entry:
  - m_axis_valid & m_axis_ready: handshake; m_axis_valid falls next cycle unless a new result loads on the same edge.
  - New result while m_axis_valid & ~m_axis_ready: the new result is discarded, the held word is unchanged, and out_overflow <= 1.
  - New result on the same edge as a handshake: the new result loads and no overflow is flagged.
- m_axis_data is stable while m_axis_valid & ~m_axis_ready.
- in_enable=0: counter and accumulators clear on the next edge (partial block abandoned). Any pending output word stays valid until accepted.
- in_enable and s_axis_valid are evaluated each cycle; no other gating.
- in_rst mid-block or with output pending: everything returns to reset values on that edge. The pending word is lost and out_overflow is cleared.
- out_overflow clears only by in_rst.

Test Plan:
- Pass-through: L=0, unsigned, m_axis_ready=1, beats 0x00050003, 0x03FF0000 -> same words on m_axis_data 1 cycle later, m_axis_valid=1 on both cycles.
- Average: L=2, unsigned, A=1,2,3,4 and B=1023 x4 -> one word 0x03FF0002 one cycle after the 4th beat; m_axis_valid=0 during the other cycles.
- Signed floor: BIT_SIGNED_DATA=1, L=1, A=0x3FF(-1) then 0x3FE(-2), B=0x001 then 0x002 -> A=-3>>>1=-2, B=3>>1=1 -> m_axis_data=0x0001FFFE.
- Backpressure: L=0, m_axis_ready=0, beats 0x00010001 then 0x00020002 -> held word 0x00010001, out_overflow=1. Raise m_axis_ready -> 0x00010001 delivered once, then m_axis_valid=0.
- Config change mid-block: L=2 at block start, in_log2_decim changed to 1 after 2 beats -> first output after 4 beats, subsequent outputs every 2 beats. in_log2_decim=15 with max 8 -> output every 256 beats.
- Abort/reset: L=2, deassert in_enable after 3 beats, then re-enable and send 4 beats of A=8 -> single output A=8 (the abandoned beats do not contribute). Assert in_rst with m_axis_valid=1 -> next cycle m_axis_valid=0, out_overflow=0.

Source files
------------

// File: rtl/axis_adc_decimator.sv
// Block-averaging decimator for a two-channel ADC sample stream.
// Each accepted beat carries channel A in the low half and channel B in the
// high half. Blocks of 2^L beats are summed per channel, and the floor of
// their mean is emitted as one AXI-Stream word held in a single-entry output
// register.
//
// Ports:
//   in_clk, in_rst        clock, synchronous active-high reset
//   in_enable             1: accept beats, 0: discard input and clear partial block
//   in_log2_decim         requested L, clamped to INT_MAX_LOG2_DECIM, latched at block start
//   s_axis_*              always-ready input stream
//   m_axis_*              averaged output stream with backpressure
//   out_overflow          sticky flag: a finished result was dropped under backpressure
module axis_adc_decimator #(
   parameter int unsigned INT_ADC_DATA_WIDTH  = 10,
   parameter int unsigned INT_AXIS_DATA_WIDTH = 32,
   parameter int unsigned INT_MAX_LOG2_DECIM  = 8,
   parameter bit          BIT_SIGNED_DATA     = 1'b0
) (
   input  logic                           in_clk,
   input  logic                           in_rst,
   input  logic                           in_enable,
   input  logic [3:0]                     in_log2_decim,
   input  logic                           s_axis_valid,
   input  logic [INT_AXIS_DATA_WIDTH-1:0] s_axis_data,
   output logic                           s_axis_ready,
   output logic                           m_axis_valid,
   input  logic                           m_axis_ready,
   output logic [INT_AXIS_DATA_WIDTH-1:0] m_axis_data,
   output logic                           out_overflow
);

   localparam int unsigned ADC_W  = INT_ADC_DATA_WIDTH;
   localparam int unsigned HALF_W = INT_AXIS_DATA_WIDTH / 2;
   localparam int unsigned ACC_W  = INT_ADC_DATA_WIDTH + INT_MAX_LOG2_DECIM;
   localparam int unsigned CNT_W  = INT_MAX_LOG2_DECIM + 1;

   if ((INT_ADC_DATA_WIDTH > INT_AXIS_DATA_WIDTH / 2) || (INT_AXIS_DATA_WIDTH % 2 != 0)) begin : g_bad_params
      $error("axis_adc_decimator: illegal INT_ADC_DATA_WIDTH / INT_AXIS_DATA_WIDTH combination");
   end

   // Extend an ADC sample to accumulator width (sign- or zero-extend).
   function automatic logic [ACC_W-1:0] ext_acc(input logic [ADC_W-1:0] s);
      logic [ACC_W-1:0] r;
      r = (BIT_SIGNED_DATA && s[ADC_W-1]) ? '1 : '0;
      r[ADC_W-1:0] = s;
      return r;
   endfunction

   // Extend an averaged sample to one output half.
   function automatic logic [HALF_W-1:0] ext_half(input logic [ADC_W-1:0] s);
      logic [HALF_W-1:0] r;
      r = (BIT_SIGNED_DATA && s[ADC_W-1]) ? '1 : '0;
      r[ADC_W-1:0] = s;
      return r;
   endfunction

   logic [3:0]                     l_blk;
   logic [3:0]                     l_in;
   logic [3:0]                     l_eff;
   logic [CNT_W-1:0]               cnt;
   logic [CNT_W-1:0]               cnt_last;
   logic [ACC_W-1:0]               acc_a;
   logic [ACC_W-1:0]               acc_b;
   logic [ACC_W-1:0]               sum_a;
   logic [ACC_W-1:0]               sum_b;
   logic signed [ACC_W-1:0]        sum_a_s;
   logic signed [ACC_W-1:0]        sum_b_s;
   logic [ACC_W-1:0]               shr_a;
   logic [ACC_W-1:0]               shr_b;
   logic [INT_AXIS_DATA_WIDTH-1:0] res;
   logic                           block_start;
   logic                           beat_ok;
   logic                           final_beat;
   logic                           unused_ok;

   assign s_axis_ready = 1'b1;

   // Averages only keep ADC_W bits, and the top bits of each input half are ignored.
   assign unused_ok = ^{s_axis_data, shr_a, shr_b};

   // Block bookkeeping, running sums and the shifted result.
   always_comb begin
      l_in        = (in_log2_decim > 4'(INT_MAX_LOG2_DECIM)) ? 4'(INT_MAX_LOG2_DECIM) : in_log2_decim;
      block_start = (cnt == '0);
      // The first beat of a block already uses the newly requested L.
      l_eff       = block_start ? l_in : l_blk;
      cnt_last    = ~({CNT_W{1'b1}} << l_eff);
      beat_ok     = s_axis_valid & in_enable;
      final_beat  = beat_ok & (cnt == cnt_last);
      sum_a       = (block_start ? '0 : acc_a) + ext_acc(s_axis_data[ADC_W-1:0]);
      sum_b       = (block_start ? '0 : acc_b) + ext_acc(s_axis_data[HALF_W +: ADC_W]);
      sum_a_s     = sum_a;
      sum_b_s     = sum_b;
      if (BIT_SIGNED_DATA) begin
         shr_a = sum_a_s >>> l_eff;
         shr_b = sum_b_s >>> l_eff;
      end else begin
         shr_a = sum_a >> l_eff;
         shr_b = sum_b >> l_eff;
      end
      res = {ext_half(shr_b[ADC_W-1:0]), ext_half(shr_a[ADC_W-1:0])};
   end

   // Accumulation state and the single-entry output register.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         l_blk        <= '0;
         cnt          <= '0;
         acc_a        <= '0;
         acc_b        <= '0;
         m_axis_valid <= 1'b0;
         m_axis_data  <= '0;
         out_overflow <= 1'b0;
      end else begin
         if (beat_ok) begin
            if (block_start) begin
               l_blk <= l_in;
            end
            acc_a <= sum_a;
            acc_b <= sum_b;
            cnt   <= final_beat ? '0 : cnt + CNT_W'(1);
         end else if (!in_enable) begin
            cnt   <= '0;
            acc_a <= '0;
            acc_b <= '0;
         end

         // A result may replace the held word only if that word leaves this edge.
         if (final_beat) begin
            if (!m_axis_valid || m_axis_ready) begin
               m_axis_data  <= res;
               m_axis_valid <= 1'b1;
            end else begin
               out_overflow <= 1'b1;
            end
         end else if (m_axis_valid && m_axis_ready) begin
            m_axis_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axis_adc_decimator.sv
// Directed testbench for axis_adc_decimator: an unsigned and a signed instance
// share all stimulus; expected words are hand-computed constants.
module tb_axis_adc_decimator;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  log2_decim;
   logic        s_valid;
   logic [31:0] s_data;
   logic        m_ready;

   logic        u_s_ready, u_m_valid, u_ovf;
   logic [31:0] u_m_data;
   logic        s_s_ready, s_m_valid, s_ovf;
   logic [31:0] s_m_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axis_adc_decimator #(
      .INT_ADC_DATA_WIDTH (10),
      .INT_AXIS_DATA_WIDTH(32),
      .INT_MAX_LOG2_DECIM (8),
      .BIT_SIGNED_DATA    (1'b0)
   ) dut_u (
      .in_clk       (clk),
      .in_rst       (rst),
      .in_enable    (en),
      .in_log2_decim(log2_decim),
      .s_axis_valid (s_valid),
      .s_axis_data  (s_data),
      .s_axis_ready (u_s_ready),
      .m_axis_valid (u_m_valid),
      .m_axis_ready (m_ready),
      .m_axis_data  (u_m_data),
      .out_overflow (u_ovf)
   );

   axis_adc_decimator #(
      .INT_ADC_DATA_WIDTH (10),
      .INT_AXIS_DATA_WIDTH(32),
      .INT_MAX_LOG2_DECIM (8),
      .BIT_SIGNED_DATA    (1'b1)
   ) dut_s (
      .in_clk       (clk),
      .in_rst       (rst),
      .in_enable    (en),
      .in_log2_decim(log2_decim),
      .s_axis_valid (s_valid),
      .s_axis_data  (s_data),
      .s_axis_ready (s_s_ready),
      .m_axis_valid (s_m_valid),
      .m_axis_ready (m_ready),
      .m_axis_data  (s_m_data),
      .out_overflow (s_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present one beat, then advance to just after the edge that takes it.
   task automatic send(input logic [31:0] d);
      s_valid = 1'b1;
      s_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int early;
      rst        = 1'b1;
      en         = 1'b1;
      log2_decim = 4'd0;
      s_valid    = 1'b0;
      s_data     = 32'h0;
      m_ready    = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(u_m_valid), 32'd0);
      check("rst_data", u_m_data, 32'h0);
      check("rst_ovf", 32'(u_ovf), 32'd0);
      check("rst_s_ready", 32'(u_s_ready), 32'd1);
      rst = 1'b0;
      idle(1);

      // Pass-through with L=0
      send(32'h0005_0003);
      check("pt0_data", u_m_data, 32'h0005_0003);
      check("pt0_valid", 32'(u_m_valid), 32'd1);
      send(32'h03FF_0000);
      check("pt1_data", u_m_data, 32'h03FF_0000);
      check("pt1_valid", 32'(u_m_valid), 32'd1);
      idle(1);
      check("pt_drop", 32'(u_m_valid), 32'd0);

      // Average of four, L=2
      log2_decim = 4'd2;
      send(32'h03FF_0001);
      check("avg_b1_valid", 32'(u_m_valid), 32'd0);
      send(32'h03FF_0002);
      check("avg_b2_valid", 32'(u_m_valid), 32'd0);
      send(32'h03FF_0003);
      check("avg_b3_valid", 32'(u_m_valid), 32'd0);
      send(32'h03FF_0004);
      check("avg_valid", 32'(u_m_valid), 32'd1);
      check("avg_data", u_m_data, 32'h03FF_0002);
      idle(1);
      check("avg_drop", 32'(u_m_valid), 32'd0);

      // Signed floor, L=1: A=-1,-2 B=1,2
      log2_decim = 4'd1;
      send(32'h0001_03FF);
      check("sgn_b1_valid", 32'(s_m_valid), 32'd0);
      send(32'h0002_03FE);
      check("sgn_valid", 32'(s_m_valid), 32'd1);
      check("sgn_data", s_m_data, 32'h0001_FFFE);
      check("uns_same_beats", u_m_data, 32'h0001_03FE);
      idle(1);

      // Backpressure, L=0
      log2_decim = 4'd0;
      m_ready    = 1'b0;
      send(32'h0001_0001);
      check("bp_first_data", u_m_data, 32'h0001_0001);
      check("bp_first_ovf", 32'(u_ovf), 32'd0);
      send(32'h0002_0002);
      check("bp_held_data", u_m_data, 32'h0001_0001);
      check("bp_held_valid", 32'(u_m_valid), 32'd1);
      check("bp_ovf", 32'(u_ovf), 32'd1);
      s_valid = 1'b0;
      m_ready = 1'b1;
      #1;
      check("bp_deliver_data", u_m_data, 32'h0001_0001);
      idle(1);
      check("bp_after_valid", 32'(u_m_valid), 32'd0);
      check("bp_ovf_sticky", 32'(u_ovf), 32'd1);

      // Mid-block L change: first block stays L=2, next uses L=1
      log2_decim = 4'd2;
      send(32'h0001_0001);
      send(32'h0002_0002);
      log2_decim = 4'd1;
      send(32'h0003_0003);
      check("cfg_b3_valid", 32'(u_m_valid), 32'd0);
      send(32'h0006_0006);
      check("cfg_blk1_valid", 32'(u_m_valid), 32'd1);
      check("cfg_blk1_data", u_m_data, 32'h0003_0003);
      send(32'h0005_0005);
      check("cfg_b5_valid", 32'(u_m_valid), 32'd0);
      send(32'h0008_0008);
      check("cfg_blk2_valid", 32'(u_m_valid), 32'd1);
      check("cfg_blk2_data", u_m_data, 32'h0006_0006);

      // L=15 clamps to 8: A=0..255 averages to 127, B=1023
      log2_decim = 4'd15;
      early = 0;
      for (int i = 0; i < 256; i++) begin
         send({16'h03FF, 16'(i)});
         if (i < 255 && u_m_valid) early++;
      end
      check("clamp_early_outputs", 32'(early), 32'd0);
      check("clamp_valid", 32'(u_m_valid), 32'd1);
      check("clamp_data", u_m_data, 32'h03FF_007F);
      idle(1);

      // Abort: three beats abandoned, then a clean block of A=8
      log2_decim = 4'd2;
      send(32'h0000_0064);
      send(32'h0000_0064);
      send(32'h0000_0064);
      en = 1'b0;
      send(32'h0000_0064);
      en = 1'b1;
      send(32'h0000_0008);
      check("abort_b1_valid", 32'(u_m_valid), 32'd0);
      send(32'h0000_0008);
      send(32'h0000_0008);
      check("abort_b3_valid", 32'(u_m_valid), 32'd0);
      send(32'h0000_0008);
      check("abort_valid", 32'(u_m_valid), 32'd1);
      check("abort_data", u_m_data, 32'h0000_0008);
      idle(1);

      // Reset with an output pending and overflow set
      log2_decim = 4'd0;
      m_ready    = 1'b0;
      send(32'h0001_0001);
      send(32'h0002_0002);
      check("prerst_valid", 32'(u_m_valid), 32'd1);
      s_valid = 1'b0;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_valid", 32'(u_m_valid), 32'd0);
      check("midrst_ovf", 32'(u_ovf), 32'd0);
      check("midrst_data", u_m_data, 32'h0);
      rst = 1'b0;
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
